// File: rtl/task_dispatch_arbiter.sv
// task_dispatch_arbiter: round-robin requester/lane arbiter feeding TaskFIFOs, with per-tree occupancy checks
module task_dispatch_arbiter #(
  parameter int PTW = 16,
  parameter int LEVEL = 4,
  parameter int TREE_NUM = 4,
  parameter int REQ_NUM = 4,
  parameter int TREE_CAP = 15,
  localparam int TREE_NUM_BITS = $clog2(TREE_NUM),
  localparam int REQ_BITS = $clog2(REQ_NUM),
  localparam int CNT_W = $clog2(TREE_CAP + 1),
  localparam int TW = PTW + TREE_NUM_BITS + 1,
  localparam int LW = $clog2(LEVEL)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [REQ_NUM-1:0]       i_req_valid,
  output logic [REQ_NUM-1:0]       o_req_ready,
  input  logic [REQ_NUM-1:0]       i_req_type,
  input  logic [TREE_NUM_BITS-1:0] i_req_treeId [0:REQ_NUM-1],
  input  logic [PTW-1:0]           i_req_data [0:REQ_NUM-1],
  output logic [LEVEL-1:0]         o_fifo_push,
  output logic [TW-1:0]            o_fifo_data [0:LEVEL-1],
  input  logic [LEVEL-1:0]         i_fifo_full,
  output logic                     o_err,
  output logic [REQ_BITS-1:0]      o_err_id,
  output logic [CNT_W-1:0]         o_tree_cnt [0:TREE_NUM-1]
);
  logic [REQ_BITS-1:0]      r_req_ptr;
  logic [LW-1:0]            r_lane_ptr;
  logic [LEVEL-1:0]         r_push;
  logic [TW-1:0]            r_data [0:LEVEL-1];
  logic                     r_err;
  logic [REQ_BITS-1:0]      r_err_id;
  logic [CNT_W-1:0]         r_cnt [0:TREE_NUM-1];
  logic [LEVEL-1:0]         w_elig;
  logic                     w_lane_ok, w_req_ok, w_gnt, w_type, w_tin, w_legal;
  logic [LW-1:0]            w_lane;
  logic [REQ_BITS-1:0]      w_req;
  logic [TREE_NUM_BITS-1:0] w_t;
  logic [CNT_W-1:0]         w_cnt;
  logic [TW-1:0]            w_pkt;
  // r_push doubles as the last-written-lane mask, blocking same-lane back-to-back writes
  assign w_elig = ~i_fifo_full & ~r_push;
  always_comb begin
    w_lane_ok = 1'b0;
    w_lane = '0;
    for (int k = LEVEL - 1; k >= 0; k--)
      if (w_elig[(int'(r_lane_ptr) + k) % LEVEL]) begin
        w_lane_ok = 1'b1;
        w_lane = LW'((int'(r_lane_ptr) + k) % LEVEL);
      end
  end
  always_comb begin
    w_req_ok = 1'b0;
    w_req = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--)
      if (i_req_valid[(int'(r_req_ptr) + k) % REQ_NUM]) begin
        w_req_ok = 1'b1;
        w_req = REQ_BITS'((int'(r_req_ptr) + k) % REQ_NUM);
      end
  end
  assign w_gnt = !i_rst && w_req_ok && w_lane_ok;
  assign w_type = i_req_type[w_req];
  assign w_t = i_req_treeId[w_req];
  assign w_tin = int'(w_t) < TREE_NUM;
  assign w_cnt = w_tin ? r_cnt[w_t] : '0;
  assign w_legal = w_tin && (w_type ? w_cnt < CNT_W'(TREE_CAP) : w_cnt != '0);
  assign w_pkt = {w_type, w_t, w_type ? i_req_data[w_req] : PTW'(0)};
  assign o_req_ready = w_gnt ? REQ_NUM'(1) << w_req : '0;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req_ptr <= '0;
      r_lane_ptr <= '0;
      r_push <= '0;
      r_data <= '{default: '0};
      r_err <= 1'b0;
      r_err_id <= '0;
      r_cnt <= '{default: '0};
    end else begin
      r_push <= '0;
      r_err <= 1'b0;
      if (w_gnt) begin
        r_req_ptr <= REQ_BITS'((int'(w_req) + 1) % REQ_NUM);
        r_lane_ptr <= LW'((int'(w_lane) + 1) % LEVEL);
        if (w_legal) begin
          r_push[w_lane] <= 1'b1;
          r_data[w_lane] <= w_pkt;
          r_cnt[w_t] <= w_type ? r_cnt[w_t] + 1'b1 : r_cnt[w_t] - 1'b1;
        end else begin
          r_err <= 1'b1;
          r_err_id <= w_req;
        end
      end
    end
  end
  assign o_fifo_push = r_push;
  assign o_fifo_data = r_data;
  assign o_err = r_err;
  assign o_err_id = r_err_id;
  assign o_tree_cnt = r_cnt;
endmodule

// File: tb/tb_task_dispatch_arbiter.sv
// tb_task_dispatch_arbiter: directed plus random stimulus, scoreboarded against a queue-based reference model
module tb_task_dispatch_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  valid = '0, ready, rtype = '0, push, full = '0;
  logic [1:0]  tree [0:3];
  logic [15:0] data [0:3];
  logic [18:0] fdata [0:3];
  logic        err;
  logic [1:0]  err_id;
  logic [3:0]  tcnt [0:3];
  typedef struct {int cyc; logic [3:0] push; logic [18:0] data; int lane; logic err; logic [1:0] err_id;} exp_t;
  exp_t q [$];
  int total = 0, bad = 0, cyc = 0;
  int m_cnt [4];
  int m_rp = 0, m_lp = 0, m_last = -1;
  task_dispatch_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .o_req_ready(ready),
    .i_req_type(rtype), .i_req_treeId(tree), .i_req_data(data),
    .o_fifo_push(push), .o_fifo_data(fdata), .i_fifo_full(full),
    .o_err(err), .o_err_id(err_id), .o_tree_cnt(tcnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask
  task automatic set_req(input int r, input bit v, input bit ty, input int tr, input int d);
    valid[r] = v;
    rtype[r] = ty;
    tree[r] = 2'(tr);
    data[r] = 16'(d);
  endtask
  // Reference model: search for the first free lane and valid requester, then apply the tree rules.
  task automatic step();
    int lane, g, t;
    bit legal;
    logic [3:0] exp_rdy;
    exp_t e;
    @(negedge clk);
    exp_rdy = '0;
    for (int i = 0; i < 4; i++) chk($sformatf("tree_cnt%0d", i), 32'(tcnt[i]), 32'(m_cnt[i]));
    if (rst) begin
      m_cnt = '{default: 0};
      m_rp = 0;
      m_lp = 0;
      m_last = -1;
    end else begin
      lane = -1;
      g = -1;
      for (int k = 0; k < 4; k++) if (lane < 0 && !full[(m_lp + k) % 4] && (m_lp + k) % 4 != m_last) lane = (m_lp + k) % 4;
      for (int k = 0; k < 4; k++) if (g < 0 && valid[(m_rp + k) % 4]) g = (m_rp + k) % 4;
      m_last = -1;
      if (lane >= 0 && g >= 0) begin
        exp_rdy[g] = 1'b1;
        t = int'(tree[g]);
        legal = rtype[g] ? m_cnt[t] < 15 : m_cnt[t] > 0;
        e.cyc = cyc + 1;
        e.lane = lane;
        e.err = !legal;
        e.err_id = 2'(g);
        e.push = legal ? 4'(1 << lane) : 4'b0;
        e.data = {rtype[g], tree[g], rtype[g] ? data[g] : 16'h0};
        q.push_back(e);
        if (legal) begin
          m_cnt[t] += rtype[g] ? 1 : -1;
          m_last = lane;
        end
        m_rp = (g + 1) % 4;
        m_lp = (lane + 1) % 4;
      end
    end
    chk("req_ready", 32'(ready), 32'(exp_rdy));
    @(posedge clk);
    cyc++;
    #1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (push != 4'b0 || err === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_output at cycle %0d: push=%b err=%b, want none", cyc, push, err);
      end else begin
        e = q.pop_front();
        chk("out_cycle", 32'(cyc), 32'(e.cyc));
        chk("fifo_push", 32'(push), 32'(e.push));
        chk("err", 32'(err), 32'(e.err));
        if (e.err) chk("err_id", 32'(err_id), 32'(e.err_id));
        else chk("fifo_data", 32'(fdata[e.lane]), 32'(e.data));
      end
    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_output at cycle %0d: push=%b err=%b, want push=%b err=%b", cyc, push, err, e.push, e.err);
    end
  end
  initial begin
    for (int r = 0; r < 4; r++) set_req(r, 1'b1, 1'b1, 0, 0);
    step();
    step();
    chk("rst_push", 32'(push), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_data0", 32'(fdata[0]), 32'h0);
    rst = 1'b0;
    valid = '0;
    set_req(0, 1'b1, 1'b1, 2, 16'h00AB);
    step();
    valid = '0;
    step();
    for (int r = 0; r < 4; r++) set_req(r, 1'b1, 1'b1, 0, 16'h1000 + r);
    repeat (8) step();
    valid = '0;
    set_req(1, 1'b1, 1'b0, 3, 0);
    step();
    valid = '0;
    full = 4'b1111;
    set_req(0, 1'b1, 1'b1, 2, 16'h0C0C);
    repeat (3) step();
    full = 4'b1011;
    repeat (3) step();
    full = '0;
    valid = '0;
    step();
    set_req(0, 1'b1, 1'b1, 1, 16'h0101);
    repeat (16) step();
    set_req(0, 1'b1, 1'b0, 1, 0);
    step();
    for (int r = 0; r < 4; r++) set_req(r, 1'b1, 1'b1, 1, r);
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 4; r++) set_req(r, 1'($urandom), 1'($urandom_range(0, 2) != 0), int'($urandom_range(0, 3)), int'($urandom));
      full = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      step();
    end
    valid = '0;
    full = '0;
    repeat (3) step();
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
